trap_shaper_rt: RTL
===================

// Module: trap_shaper_rt
// PURPOSE
//  Next-generation trapezoidal pulse shaper for the ADC filter chain. Runtime-programmable rise (K),
//  flat-top (L) and pole-zero (M) settings; valid/ready input handshake; saturating scaled output.
//  Sits between the ADC capture register and the pulse-height/trigger logic.
//  Replaces fixed-K/L parameter filters with one instance reusable across detector channels.
// PARAMETERS
//  DATA_W  12  input sample width, signed two's complement (package_settings::SIZE_ADC_DATA)
//  AW      6   delay-buffer address width; buffer depth DMAX = 2**AW samples
//  M_W     10  width of unsigned pole-zero coefficient cfg_m
//  ACC_W   40  width of the internal accumulators p and s, signed
//  OUT_W   16  output width, signed
//  SHIFT   8   arithmetic right shift applied to s before saturation
// PORTS
//  clk        in   1       clock
//  reset      in   1       synchronous, active-high reset
//  in_data    in   DATA_W  signed ADC sample
//  in_valid   in   1       in_data valid
//  in_ready   out  1       shaper accepts a sample; a transfer happens when in_valid & in_ready
//  cfg_k      in   AW      rise length K, range 1..DMAX-2
//  cfg_l      in   AW      K+flat-top length L, range K..DMAX-1-K
//  cfg_m      in   M_W     pole-zero coefficient M
//  cfg_load   in   1       1-cycle pulse: check cfg_* and, if legal, latch them and start FLUSH
//  cfg_err    out  1       1-cycle pulse: cfg_load rejected because K/L out of range
//  out_data   out  OUT_W   shaped output, saturated
//  out_valid  out  1       out_data valid (1-cycle pulse per accepted sample)
//  out_settled out 1       qualifies out_valid: K+L samples accepted since the last FLUSH
//  sat_flag   out  1       sticky; set on any saturation, cleared by reset or cfg_load
// BEHAVIOUR
//  Math, per accepted sample x(n), with x(n-j)=0 before flush completion:
//   d(n)=x(n)-x(n-K)-x(n-L)+x(n-K-L); p(n)=p(n-1)+d(n); r(n)=p(n)+M*d(n); s(n)=s(n-1)+r(n)
//   out = sat_OUT_W(s(n) >>> SHIFT). All arithmetic is signed ACC_W; p and s wrap, no saturation.
//   Saturation clamps to +2**(OUT_W-1)-1 / -2**(OUT_W-1).
//  Pipeline: fixed latency 5 cycles from the accepted transfer to out_valid. Stages only advance
//   on accepted samples; a bubble (no transfer) produces no out_valid.
//  FSM (filter_shaper_pkg::state_t): FLUSH -> WARM -> RUN.
//   FLUSH: in_ready=0; writes zeros to all DMAX buffer words (DMAX cycles); clears p, s, pipeline.
//          Then WARM with settle counter = 0.
//   WARM:  in_ready=1; each accepted sample increments counter; at K+L accepted samples -> RUN.
//   RUN:   in_ready=1; out_settled=1 on every out_valid.
//  cfg_load legal in any state: latch cfg, clear sat_flag, abort pipeline (in-flight out_valid
//   suppressed), enter FLUSH next cycle. Illegal cfg: cfg_err=1 one cycle, config and state kept.
//  Sample accepted in the same cycle as cfg_load is discarded.
//  Buffer: circular; write pointer wraps DMAX-1 -> 0; taps read at wp-K, wp-L, wp-K-L mod DMAX.
//  Reset: acts as cfg_load of defaults K=4, L=8, M=0 -> FLUSH; out_data=0, out_valid=0,
//   out_settled=0, cfg_err=0, sat_flag=0, in_ready=0 until FLUSH completes.
// CONFIGURATION
//  TRAP_PEAK_EN defined: adds ports peak_thr (in, OUT_W), peak_data (out, OUT_W),
//   peak_valid (out, 1). When settled out_data rises above peak_thr, the running maximum is
//   tracked; on the first settled output <= peak_thr, peak_valid pulses 1 cycle with the maximum.
//   Cleared by reset/cfg_load.
//  TRAP_PEAK_EN undefined: ports and logic absent; all other behaviour identical.
// STRUCTURE
//  filter_shaper_pkg: state_t enum, default K/L/M constants, sat() function, LATENCY=5 localparam.
//  Sub-module trap_delay_ram: DMAX x DATA_W circular buffer, 1 write + 3 registered read ports.
// TESTING
//  Step A=100, K=4, L=10, M=0, SHIFT=0 -> settled out 100,200,300,400, 400x6, 300,200,100, 0.
//  Reset -> in_ready=0 for 64 cycles (AW=6), first out_valid 5 cycles after first transfer.
//  cfg_load K=40, L=30 -> cfg_err pulse; old config still active, output unchanged.
//  Full-scale step 2047, K=30, SHIFT=0 -> out clamps at 32767, sat_flag stays 1 until cfg_load.
//  cfg_load mid-pulse -> no out_valid from in-flight samples, FLUSH, out_settled=0 for K+L samples.
//  TRAP_PEAK_EN, peak_thr=250, first test stimulus -> one peak_valid, peak_data=400.

Source files
------------

// File: rtl/filter_shaper_pkg.sv
// filter_shaper_pkg: shaper FSM states, reset-default K/L/M, pipeline latency and the saturation helper
package filter_shaper_pkg;
  typedef enum logic [1:0] {FLUSH, WARM, RUN} state_t;
  localparam int DEF_K = 4;
  localparam int DEF_L = 8;
  localparam int DEF_M = 0;
  localparam int LATENCY = 5;
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/trap_delay_ram.sv
// trap_delay_ram: circular sample buffer, one write port and three registered read taps
module trap_delay_ram #(
  parameter int AW = 6,
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd0,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd0 <= mem[ra0];
    rd1 <= mem[ra1];
    rd2 <= mem[ra2];
  end
endmodule

// File: rtl/trap_shaper_rt.sv
// trap_shaper_rt: runtime-configurable trapezoidal shaper with pole-zero correction and saturating output
// Optional peak capture port set enabled by defining TRAP_PEAK_EN.
module trap_shaper_rt
  import filter_shaper_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int AW     = 6,
  parameter int M_W    = 10,
  parameter int ACC_W  = 40,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef TRAP_PEAK_EN
  input  logic signed [OUT_W-1:0]  peak_thr,
  output logic signed [OUT_W-1:0]  peak_data,
  output logic                     peak_valid,
`endif
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            cfg_k,
  input  logic [AW-1:0]            cfg_l,
  input  logic [M_W-1:0]           cfg_m,
  input  logic                     cfg_load,
  output logic                     cfg_err,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  output logic                     out_settled,
  output logic                     sat_flag
);
  state_t state, state_n;
  logic [AW-1:0] k_q, l_q, wp, cnt;
  logic [M_W-1:0] m_q;
  logic cfg_ok, load, acc;
  logic [LATENCY-1:0] v, st;
  logic signed [DATA_W-1:0] x1, t0, t1, t2;
  logic signed [ACC_W-1:0] d2, p, r3, s, mx;
  logic signed [63:0] shx, satv;
  assign cfg_ok = cfg_k != '0 && cfg_l >= cfg_k && ({1'b0, cfg_k} + {1'b0, cfg_l}) <= (AW+1)'(2**AW - 1);
  assign load = cfg_load & cfg_ok;
  assign in_ready = state != FLUSH;
  assign acc = in_valid & in_ready & ~load;
  assign out_valid = v[LATENCY-1];
  assign out_settled = v[LATENCY-1] & st[LATENCY-1];
  assign mx = ACC_W'($signed({1'b0, m_q}));
  assign shx = 64'(s >>> SHIFT);
  assign satv = sat(shx, OUT_W);
  always_ff @(posedge clk)
    if (reset) state <= FLUSH;
    else state <= state_n;
  always_comb
    state_n = load ? FLUSH :
              (state == FLUSH && &wp) ? WARM :
              (state == WARM && acc && ({1'b0, cnt} + (AW+1)'(1)) == ({1'b0, k_q} + {1'b0, l_q})) ? RUN :
              state;
  always_ff @(posedge clk)
    if (reset) begin
      k_q <= AW'(DEF_K);
      l_q <= AW'(DEF_L);
      m_q <= M_W'(DEF_M);
      wp <= '0;
      cnt <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_load & ~cfg_ok;
      if (load) begin
        k_q <= cfg_k;
        l_q <= cfg_l;
        m_q <= cfg_m;
        wp <= '0;
        cnt <= '0;
      end else if (state == FLUSH) begin
        wp <= wp + 1'b1;
        cnt <= '0;
      end else if (acc) begin
        wp <= wp + 1'b1;
        cnt <= cnt + 1'b1;
      end
    end
  // FLUSH reuses the write pointer to sweep zeros through every buffer word
  trap_delay_ram #(.AW(AW), .DW(DATA_W)) u_ram (
    .clk(clk),
    .we(state == FLUSH || acc),
    .wa(wp),
    .ra0(wp - k_q),
    .ra1(wp - l_q),
    .ra2(wp - k_q - l_q),
    .wd(state == FLUSH ? '0 : in_data),
    .rd0(t0),
    .rd1(t1),
    .rd2(t2)
  );
  always_ff @(posedge clk) begin
    x1 <= in_data;
    if (reset | load) begin
      v <= '0;
      st <= '0;
      d2 <= '0;
      p <= '0;
      r3 <= '0;
      s <= '0;
      out_data <= '0;
      sat_flag <= 1'b0;
    end else begin
      v <= {v[LATENCY-2:0], acc};
      st <= {st[LATENCY-2:0], state == RUN};
      if (v[0]) d2 <= ACC_W'(x1) - ACC_W'(t0) - ACC_W'(t1) + ACC_W'(t2);
      if (v[1]) begin
        p <= p + d2;
        r3 <= p + d2 + mx * d2;
      end
      if (v[2]) s <= s + r3;
      if (v[3]) begin
        out_data <= satv[OUT_W-1:0];
        sat_flag <= sat_flag | (satv != shx);
      end
    end
  end
`ifdef TRAP_PEAK_EN
  logic pk_on;
  logic signed [OUT_W-1:0] pk_max;
  always_ff @(posedge clk)
    if (reset | load) begin
      pk_on <= 1'b0;
      pk_max <= '0;
      peak_valid <= 1'b0;
      peak_data <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (out_settled) begin
        if (out_data > peak_thr) begin
          pk_on <= 1'b1;
          pk_max <= (!pk_on || out_data > pk_max) ? out_data : pk_max;
        end else if (pk_on) begin
          pk_on <= 1'b0;
          peak_valid <= 1'b1;
          peak_data <= pk_max;
        end
      end
    end
`endif
endmodule
